// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI transmit path.
//   SPI_DATA_W        word width presented to the master's din
//   SCLK_HALF         clk cycles per sclk half-period in the master
//   SPI_HOLD_CYCLES   clk cycles new_data is held (one full sclk period)
//   SPI_FRAME_CYCLES  clk cycles from new_data rise to end of inter-frame gap
//   feeder_state_t    feeder FSM states
package spi_pkg;

   localparam int unsigned SPI_DATA_W       = 12;
   localparam int unsigned SCLK_HALF        = 6;
   localparam int unsigned SPI_HOLD_CYCLES  = 2 * SCLK_HALF;
   // 14 sclk periods cover a master frame; two more periods give the slave
   // side margin before the next word is offered.
   localparam int unsigned SPI_FRAME_CYCLES = 16 * 2 * SCLK_HALF;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      GAP
   } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush and occupancy count.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en_i      push wr_data_i (ignored when full or flushing)
//   rd_en_i      pop head (ignored when empty or flushing)
//   flush_i      clear pointers and level; wins over a same-cycle push
//   rd_data_o    current head (combinational from storage)
//   level_o      occupancy 0..DEPTH
//   full_o       level_o == DEPTH
//   empty_o      level_o == 0
module sync_fifo #(
   parameter  int unsigned DATA_W = 12,
   parameter  int unsigned DEPTH  = 8,
   localparam int unsigned LW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [LW-1:0]     level_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              wr_ok, rd_ok;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign rd_data_o = mem[rd_ptr_q];

   assign wr_ok = wr_en_i & ~full_o  & ~flush_i;
   assign rd_ok = rd_en_i & ~empty_o & ~flush_i;

   // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: buffers system-side words and paces them into the SPI
// master, which has no handshake of its own.
//   clk       system clock (shared with the master)
//   reset     asynchronous active-low reset
//   wr_valid  write request; accepted when wr_valid & wr_ready
//   wr_data   word to transmit
//   wr_ready  FIFO not full
//   flush     synchronous FIFO clear; the frame in flight continues
//   new_data  to master new_data, high for HOLD_CYCLES
//   din       to master din, registered, changes only on a pop
//   busy      a frame is in progress
//   level     FIFO occupancy
module spi_tx_feeder
   import spi_pkg::*;
#(
   parameter  int unsigned DATA_W       = SPI_DATA_W,
   parameter  int unsigned DEPTH        = 8,
   parameter  int unsigned HOLD_CYCLES  = SPI_HOLD_CYCLES,
   parameter  int unsigned FRAME_CYCLES = SPI_FRAME_CYCLES,
   localparam int unsigned LW           = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              flush,
   output logic              new_data,
   output logic [DATA_W-1:0] din,
   output logic              busy,
   output logic [LW-1:0]     level
);

   localparam int unsigned     TW         = $clog2(FRAME_CYCLES);
   localparam logic [TW-1:0]   HOLD_LAST  = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]   FRAME_LAST = TW'(FRAME_CYCLES - 1);

   feeder_state_t     state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              new_data_q, new_data_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              pop;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .wr_en_i   (wr_valid & wr_ready),
      .wr_data_i (wr_data),
      .rd_en_i   (pop),
      .flush_i   (flush),
      .rd_data_o (fifo_head),
      .level_o   (level),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign wr_ready = ~fifo_full;
   assign new_data = new_data_q;
   assign din      = din_q;
   assign busy     = (state_q != IDLE);

   // The timer runs from the pop edge through HOLD and GAP; the terminal
   // compare in GAP restarts it, so it never needs to saturate.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      new_data_d = new_data_q;
      din_d      = din_q;
      pop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d    = HOLD;
               timer_d    = '0;
               new_data_d = 1'b1;
               din_d      = fifo_head;
               pop        = 1'b1;
            end
         end
         HOLD: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == HOLD_LAST) begin
               state_d    = GAP;
               new_data_d = 1'b0;
            end
         end
         GAP: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == FRAME_LAST) begin
               state_d = IDLE;
               timer_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            timer_d    = '0;
            new_data_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         new_data_q <= 1'b0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         new_data_q <= new_data_d;
         din_q      <= din_d;
      end
   end

endmodule
